bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  conversion request; sampled on a rising edge of clk.
REQ-004 hundreds  input  2  BCD hundreds digit (0-2 valid).
REQ-005 tens  input  4  BCD tens digit (0-9 valid).
REQ-006 ones  input  4  BCD ones digit (0-9 valid).
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  single-cycle pulse when a result is written to bin.
REQ-009 bin  output  8  unsigned binary result, registered.
REQ-010 err  output  1  range/validity flag for the current bin; registered.

Function
REQ-011 Algorithm: reverse double-dabble over an 18-bit shift register {hundreds,tens,ones,bin_sr[7:0]}.
REQ-012 Each iteration: shift the whole register right by 1, then apply sub3 to the tens and ones nibbles.
REQ-013 States IDLE, SHIFT, DONE; the state register and a 3-bit iteration counter reset to IDLE and 0.
REQ-014 IDLE: start=1 captures the digits into the shift register, clears bin_sr and the counter, and moves to SHIFT.
REQ-015 SHIFT: one iteration per cycle for exactly 8 cycles; after the 8th cycle, go to DONE.
REQ-016 DONE: done=1 for one cycle; bin and err are loaded on entry to DONE; next state is IDLE, or SHIFT if start=1, with that start handled as in IDLE.
REQ-017 Latency: start sampled at edge k gives busy=1 for cycles k+1..k+8 and done=1 in cycle k+9.
REQ-018 start while in SHIFT is ignored, and the digits are not recaptured.
REQ-019 bin and err hold their last values until the next DONE.
REQ-020 Digit inputs are sampled only on the start-accept edge; later changes have no effect.
REQ-021 Full-scale 255 (2,5,5) yields bin=8'hFF with err=0; no wrap-around occurs for valid inputs.

Reset
REQ-022 rst=1 forces state to IDLE, counter to 0, shift register to 0, and busy=0, done=0, bin=8'h00, err=0 immediately, without waiting for clk.
REQ-023 Reset in the middle of a conversion abandons it; no done pulse follows.
REQ-024 The first start after rst is released is accepted normally.

Configuration
REQ-025 Macro BCD_RANGE_CHECK_EN.
REQ-026 Defined: at start-accept, any digit >9, hundreds=3, or a value >255 sets a pending error; at DONE this gives err=1 and bin=8'hFF. Timing is unchanged.
REQ-027 Undefined: err is tied to 0, and bin for invalid input is unspecified.

Structure
REQ-028 A shared package bcd_pkg holds the state enum, N_ITER=8, BIN_W=8 and the digit width constant.
REQ-029 Sub-module sub3 is the combinational nibble corrector: out = in-3 if in>=8, else in. It is the inverse of the team's existing add-3 cell.
REQ-030 bcd_to_binary instantiates two sub3 cells (tens and ones); the hundreds nibble needs none.

Verification
REQ-031 Input 2,5,5 with a 1-cycle start: bin=8'hFF, err=0, done exactly 9 cycles after start, busy high for 8 cycles.
REQ-032 Inputs 0,0,0, 1,2,8 and 1,9,9: bin=8'h00, 8'h80 and 8'hC7 respectively; back-to-back start during DONE gives done pulses 9 cycles apart.
REQ-033 start 1,0,0, then start 0,0,7 three cycles later: the second start is ignored and bin=8'h64.
REQ-034 With BCD_RANGE_CHECK_EN, tens=4'hA or input 2,5,6: err=1, bin=8'hFF. Without the macro, err stays 0.
REQ-035 rst asserted in SHIFT cycle 4: all outputs go to 0 immediately, no done pulse follows, and the next start converts correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD to binary converter.
// Holds the FSM state enum, widths and the input range helper.
package bcd_pkg;

  localparam int N_ITER = 8;
  localparam int BIN_W  = 8;
  localparam int DIG_W  = 4;
  localparam int HUN_W  = 2;
  localparam int SR_W   = HUN_W + 2 * DIG_W + BIN_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic bcd_invalid(
    input logic [HUN_W-1:0] h,
    input logic [DIG_W-1:0] t,
    input logic [DIG_W-1:0] o
  );
    int v;
    v = int'(h) * 100 + int'(t) * 10 + int'(o);
    return (t > 4'd9) || (o > 4'd9) ||
           (h == 2'd3) || (v > 255);
  endfunction

endpackage

// File: rtl/bcd_to_binary_sub3.sv
// Nibble corrector for reverse double-dabble.
// Undoes the add-3 step: subtract 3 when the nibble is 8 or more.
module sub3 (
  input  logic [3:0] a,
  output logic [3:0] y
);

  assign y = (a >= 4'd8) ? a - 4'd3 : a;

endmodule

// File: rtl/bcd_to_binary.sv
// Three-digit BCD to 8-bit binary, reverse double-dabble, 8 cycles.
// Define BCD_RANGE_CHECK_EN to flag invalid digits or values over 255.
module bcd_to_binary
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [HUN_W-1:0] hundreds,
  input  logic [DIG_W-1:0] tens,
  input  logic [DIG_W-1:0] ones,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] bin,
  output logic             err
);

  localparam int ONES_LO = BIN_W;
  localparam int TENS_LO = BIN_W + DIG_W;
  localparam int HUN_LO  = BIN_W + 2 * DIG_W;

  state_t          state;
  state_t          state_nx;
  logic [2:0]      cnt;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_sh;
  logic [SR_W-1:0] sr_fix;
  logic [3:0]      tens_fx;
  logic [3:0]      ones_fx;
  logic            accept;
  logic            last;

  assign sr_sh = sr >> 1;

  sub3 u_tens (
    .a (sr_sh[TENS_LO +: DIG_W]),
    .y (tens_fx)
  );

  sub3 u_ones (
    .a (sr_sh[ONES_LO +: DIG_W]),
    .y (ones_fx)
  );

  assign sr_fix = {sr_sh[HUN_LO +: HUN_W],
                   tens_fx, ones_fx,
                   sr_sh[BIN_W-1:0]};

  assign accept = start &&
                  (state == IDLE || state == DONE);
  assign last   = (state == SHIFT) &&
                  (cnt == 3'(N_ITER - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sr  <= {hundreds, tens, ones, {BIN_W{1'b0}}};
        cnt <= '0;
      end else if (state == SHIFT) begin
        sr  <= sr_fix;
        cnt <= cnt + 3'd1;
      end
    end
  end

`ifdef BCD_RANGE_CHECK_EN
  logic pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      bin  <= '0;
      err  <= 1'b0;
    end else begin
      if (accept)
        pend <= bcd_invalid(hundreds, tens, ones);
      if (last) begin
        bin <= pend ? {BIN_W{1'b1}} : sr_fix[BIN_W-1:0];
        err <= pend;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bin <= '0;
    else if (last)
      bin <= sr_fix[BIN_W-1:0];
  end

  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary with a result scoreboard.
// Build with or without BCD_RANGE_CHECK_EN.
module tb_bcd_to_binary;

  typedef struct {
    logic [7:0] bin;
    logic       err;
    logic       chk_bin;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       done;
  logic [7:0] bin;
  logic       err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t q[$];

  bcd_to_binary dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .busy     (busy),
    .done     (done),
    .bin      (bin),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(int h, int t, int o, int k);
    exp_t e;
    int   v;
    logic bad;
    v   = h * 100 + t * 10 + o;
    bad = (t > 9) || (o > 9) || (h == 3) || (v > 255);
    e.cyc     = k + 8;
    e.err     = 1'b0;
    e.chk_bin = 1'b1;
    e.bin     = 8'(v);
`ifdef BCD_RANGE_CHECK_EN
    if (bad) begin
      e.bin = 8'hFF;
      e.err = 1'b1;
    end
`else
    if (bad) e.chk_bin = 1'b0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_done: cyc %0d, queue empty", cyc);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_bin) begin
          checks++;
          assert (bin === e.bin) else begin
            errors++;
            $error("FAIL bin: got %h want %h", bin, e.bin);
          end
        end
        checks++;
        assert (err === e.err) else begin
          errors++;
          $error("FAIL err: got %b want %b", err, e.err);
        end
        checks++;
        assert (cyc === e.cyc) else begin
          errors++;
          $error("FAIL done_cycle: got %0d want %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic do_start(input int h, input int t, input int o);
    start    = 1'b1;
    hundreds = 2'(h);
    tens     = 4'(t);
    ones     = 4'(o);
    @(posedge clk);
    #1;
    q.push_back(model(h, t, o, cyc));
    start    = 1'b0;
    hundreds = 2'($urandom);
    tens     = 4'($urandom);
    ones     = 4'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("FAIL wait_done: done %b want 1", done);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: pending %0d want 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    checks++;
    assert ({busy, done, bin, err} === 11'h0) else begin
      errors++;
      $error("FAIL %s: busy %b done %b bin %h err %b want 0",
             tag, busy, done, bin, err);
    end
  endtask

  initial begin
    int v;
    int dc;
    rst      = 1'b1;
    start    = 1'b0;
    hundreds = '0;
    tens     = '0;
    ones     = '0;
    #1;
    chk_zero("reset_state");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    do_start(2, 5, 5);
    for (int i = 0; i < 8; i++) begin
      checks++;
      assert (busy === 1'b1) else begin
        errors++;
        $error("FAIL busy_%0d: got %b want 1", i, busy);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    assert ({busy, done} === 2'b01) else begin
      errors++;
      $error("FAIL busy_done_end: got %b want 01", {busy, done});
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (bin === 8'hFF) else begin
      errors++;
      $error("FAIL bin_hold: got %h want ff", bin);
    end

    do_start(0, 0, 0);
    wait_done();
    do_start(1, 2, 8);
    wait_done();
    do_start(1, 9, 9);
    drain();

    do_start(1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    start    = 1'b1;
    hundreds = 2'd0;
    tens     = 4'd0;
    ones     = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    do_start(1, 10, 5);
    drain();
    do_start(2, 5, 6);
    drain();

    for (int i = 0; i < 4; i++) begin
      v = int'($urandom_range(255));
      do_start(v / 100, (v / 10) % 10, v % 10);
      drain();
    end

    do_start(1, 2, 3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("reset_mid_shift");
    q.delete();
    dc = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    assert (done_cnt === dc) else begin
      errors++;
      $error("FAIL done_after_reset: got %0d want %0d", done_cnt, dc);
    end
    do_start(2, 0, 9);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
